// File: rtl/tube_parasite_master_if.sv
// Request/response handshake plus the parasite-side Tube register bus.
// "master" is the view of the bus initiator (tube_parasite_master).
// "slave" is the view of its environment: the parasite core that issues
// requests and the Tube responder that drives p_data_in.
interface tube_parasite_master_if;
    // Request channel from the parasite core
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [1:0] req_fifo;
    logic       req_wait;
    logic [7:0] req_wdata;

    // Completion channel back to the parasite core
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;

    // Tube register bus, parasite side
    logic [2:0] p_addr;
    logic       p_cs_b;
    logic       p_rd_b;
    logic       p_wr_b;
    logic [7:0] p_data_out;
    logic       p_data_oe;
    logic [7:0] p_data_in;

    modport master (
        input  req_valid, req_wr, req_fifo, req_wait, req_wdata, p_data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output p_addr, p_cs_b, p_rd_b, p_wr_b, p_data_out, p_data_oe
    );

    modport slave (
        output req_valid, req_wr, req_fifo, req_wait, req_wdata, p_data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  p_addr, p_cs_b, p_rd_b, p_wr_b, p_data_out, p_data_oe
    );
endinterface

// File: rtl/tube_parasite_master.sv
// Tube parasite-side bus initiator.
// Turns single-register read/write requests into timed p_cs_b/p_rd_b/p_wr_b
// cycles. With req_wait set, the FIFO status register is polled until the
// FIFO reports ready (bit7 for reads, bit6 for writes) or the poll budget
// runs out. All bus and response outputs are registered.
// Optional feature: define TUBE_PARASITE_MASTER_IRQ_SYNC_EN to add the
// synchronised irq level and nmi falling-edge pulse outputs.
module tube_parasite_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic p_clk,
    input  logic p_rst,
`ifdef TUBE_PARASITE_MASTER_IRQ_SYNC_EN
    input  logic p_irq_b,
    input  logic p_nmi_b,
    output logic irq,
    output logic nmi_pulse,
`endif
    tube_parasite_master_if.master bus
);

    // Phase counter only has to reach the longest phase length minus one.
    localparam int unsigned MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_PH = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int unsigned CNT_W  = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);
    localparam int unsigned POLL_W = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        StIdle,
        StPSetup,
        StPStrobe,
        StPHold,
        StPEval,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic              lat_wr;
    logic [1:0]        lat_fifo;
    logic [7:0]        lat_wdata;
    // Holds the last status byte during polling, then the read data.
    logic [7:0]        cap;

    logic setup_last;
    logic strobe_last;
    logic hold_last;
    logic status_ready;
    logic poll_exhausted;

    assign setup_last  = (32'(phase_cnt) == SETUP_CYC - 32'd1);
    assign strobe_last = (32'(phase_cnt) == STROBE_CYC - 32'd1);
    assign hold_last   = (32'(phase_cnt) == HOLD_CYC - 32'd1);

    // Bit7 = data available (reads), bit6 = space available (writes).
    // FIFO 3 bit7 is taken as-is; M-flag handling is left to software.
    assign status_ready = lat_wr ? cap[6] : cap[7];

    // True when the poll that just failed is the last one allowed.
    assign poll_exhausted = (POLL_LIMIT != 0) && ((32'(poll_cnt) + 32'd1) >= POLL_LIMIT);

    // Request sequencer: state, phase/poll counters and all registered outputs.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state           <= StIdle;
            phase_cnt       <= '0;
            poll_cnt        <= '0;
            lat_wr          <= 1'b0;
            lat_fifo        <= '0;
            lat_wdata       <= '0;
            cap             <= '0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.p_addr      <= '0;
            bus.p_cs_b      <= 1'b1;
            bus.p_rd_b      <= 1'b1;
            bus.p_wr_b      <= 1'b1;
            bus.p_data_out  <= '0;
            bus.p_data_oe   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    bus.rsp_valid   <= 1'b0;
                    bus.rsp_timeout <= 1'b0;
                    if (bus.req_valid && bus.req_ready) begin
                        lat_wr        <= bus.req_wr;
                        lat_fifo      <= bus.req_fifo;
                        lat_wdata     <= bus.req_wdata;
                        poll_cnt      <= '0;
                        phase_cnt     <= '0;
                        bus.req_ready <= 1'b0;
                        bus.p_cs_b    <= 1'b0;
                        if (bus.req_wait) begin
                            state      <= StPSetup;
                            bus.p_addr <= {bus.req_fifo, 1'b0};
                        end else begin
                            state      <= StSetup;
                            bus.p_addr <= {bus.req_fifo, 1'b1};
                            // Write data goes out with chip select so it is
                            // stable well before and after the strobe.
                            if (bus.req_wr) begin
                                bus.p_data_oe  <= 1'b1;
                                bus.p_data_out <= bus.req_wdata;
                            end
                        end
                    end
                end

                StPSetup: begin
                    if (setup_last) begin
                        phase_cnt  <= '0;
                        state      <= StPStrobe;
                        bus.p_rd_b <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StPStrobe: begin
                    if (strobe_last) begin
                        phase_cnt  <= '0;
                        state      <= StPHold;
                        bus.p_rd_b <= 1'b1;
                        cap        <= bus.p_data_in;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StPHold: begin
                    if (hold_last) begin
                        phase_cnt  <= '0;
                        state      <= StPEval;
                        bus.p_cs_b <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StPEval: begin
                    if (status_ready) begin
                        state      <= StSetup;
                        bus.p_cs_b <= 1'b0;
                        bus.p_addr <= {lat_fifo, 1'b1};
                        if (lat_wr) begin
                            bus.p_data_oe  <= 1'b1;
                            bus.p_data_out <= lat_wdata;
                        end
                    end else begin
                        if (POLL_LIMIT != 0 && 32'(poll_cnt) < POLL_LIMIT) begin
                            poll_cnt <= poll_cnt + POLL_W'(1);
                        end
                        if (poll_exhausted) begin
                            // Give up without touching the data register.
                            state           <= StResp;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_timeout <= 1'b1;
                            bus.rsp_rdata   <= cap;
                        end else begin
                            state      <= StPSetup;
                            bus.p_cs_b <= 1'b0;
                            bus.p_addr <= {lat_fifo, 1'b0};
                        end
                    end
                end

                StSetup: begin
                    if (setup_last) begin
                        phase_cnt  <= '0;
                        state      <= StStrobe;
                        bus.p_rd_b <= lat_wr;
                        bus.p_wr_b <= ~lat_wr;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StStrobe: begin
                    if (strobe_last) begin
                        phase_cnt  <= '0;
                        state      <= StHold;
                        bus.p_rd_b <= 1'b1;
                        bus.p_wr_b <= 1'b1;
                        if (!lat_wr) begin
                            cap <= bus.p_data_in;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StHold: begin
                    if (hold_last) begin
                        phase_cnt       <= '0;
                        state           <= StResp;
                        bus.p_cs_b      <= 1'b1;
                        bus.p_data_oe   <= 1'b0;
                        bus.p_data_out  <= '0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_rdata   <= lat_wr ? 8'h00 : cap;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                StResp: begin
                    // ready is withheld here so p_cs_b stays high for at
                    // least RESP plus one IDLE cycle between accesses.
                    bus.rsp_valid   <= 1'b0;
                    bus.rsp_timeout <= 1'b0;
                    bus.req_ready   <= 1'b1;
                    state           <= StIdle;
                end

                default: begin
                    state         <= StIdle;
                    bus.req_ready <= 1'b1;
                    bus.p_cs_b    <= 1'b1;
                    bus.p_rd_b    <= 1'b1;
                    bus.p_wr_b    <= 1'b1;
                    bus.p_data_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef TUBE_PARASITE_MASTER_IRQ_SYNC_EN
    logic irq_s1;
    logic nmi_s1;
    logic nmi_s2;
    logic nmi_s3;

    // Two-flop synchronisers; the second irq flop stores the inverted level.
    // Reset to the inactive level so no edge is seen coming out of reset.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            irq_s1    <= 1'b1;
            irq       <= 1'b0;
            nmi_s1    <= 1'b1;
            nmi_s2    <= 1'b1;
            nmi_s3    <= 1'b1;
            nmi_pulse <= 1'b0;
        end else begin
            irq_s1    <= p_irq_b;
            irq       <= ~irq_s1;
            nmi_s1    <= p_nmi_b;
            nmi_s2    <= nmi_s1;
            nmi_s3    <= nmi_s2;
            nmi_pulse <= nmi_s3 & ~nmi_s2;
        end
    end
`endif

endmodule

// File: doc/tube_parasite_master.md
Name: tube_parasite_master

Overview:
- Synchronous bus initiator that drives the parasite side of the Tube register interface (p_addr, p_cs_b, p_rd_b, p_wr_b, p_data) on behalf of an internal parasite core.
- Accepts single-register read/write requests on a valid/ready handshake and generates timed strobes.
- Optionally polls the FIFO status register until the FIFO is ready, then returns read data or a write acknowledge.
- Sits between the parasite CPU/soft core and the Tube responder; the top level builds the tristate p_data pad from p_data_out/p_data_oe.

Parameters:
- SETUP_CYC, 1: cycles p_cs_b/p_addr/write data are valid before the strobe falls (min 1).
- STROBE_CYC, 2: cycles p_rd_b or p_wr_b is held low (min 1).
- HOLD_CYC, 1: cycles p_cs_b/p_addr/write data are held after the strobe rises (min 1).
- POLL_LIMIT, 1024: maximum status polls before timeout; 0 means poll forever.

Ports:
- p_clk  in  1  parasite clock
- p_rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_fifo  in  2  FIFO select 0..3 (FIFO 1..4)
- req_wait  in  1  1 = poll the status register before the data access
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, or last status byte on timeout
- rsp_timeout  out  1  qualifies rsp_valid
- p_addr  out  3  Tube register address
- p_cs_b  out  1  chip select, active low
- p_rd_b  out  1  read strobe, active low
- p_wr_b  out  1  write strobe, active low
- p_data_out  out  8  write data to pad
- p_data_oe  out  1  pad output enable
- p_data_in  in  8  read data from pad

Behaviour:
- Reset values (synchronous, p_rst high at the edge):
  - p_cs_b = p_rd_b = p_wr_b = 1, p_addr = 0, p_data_out = 0, p_data_oe = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0, state = IDLE, req_ready = 1.
  - All outputs are registered.
- Address map:
  - status address = {req_fifo, 0}; data address = {req_fifo, 1}.
- Acceptance: req_valid & req_ready at an edge latches req_wr, req_fifo, req_wait and req_wdata. The next state is SETUP, or P_SETUP if req_wait = 1.
- States: IDLE, P_SETUP, P_STROBE, P_HOLD, P_EVAL, SETUP, STROBE, HOLD, RESP.
- Phase timing:
  - SETUP: p_cs_b = 0 and p_addr valid for SETUP_CYC cycles.
  - STROBE: p_rd_b (read) or p_wr_b (write) = 0 for STROBE_CYC cycles.
  - HOLD: strobe back to 1; p_cs_b, p_addr and write data held for HOLD_CYC cycles.
  - Write data: p_data_oe = 1 and p_data_out = wdata from the first SETUP cycle through the last HOLD cycle. This guarantees data is stable at the p_wr_b rising edge.
- Read capture: p_data_in is registered at the edge ending the last STROBE/P_STROBE cycle.
- Poll sequence:
  - P_SETUP/P_STROBE/P_HOLD perform a read of the status address with identical timing.
  - P_EVAL is one cycle with p_cs_b = 1.
  - Ready condition: status bit7 = 1 for reads (data available); status bit6 = 1 for writes (space available).
  - For FIFO 3 reads, bit7 is used as-is; software owns the M-flag semantics.
- P_EVAL transitions:
  - Ready: go to SETUP.
  - Not ready: increment a poll counter wide enough for POLL_LIMIT.
  - If POLL_LIMIT != 0 and the count reaches POLL_LIMIT: go to RESP with rsp_timeout = 1 and rsp_rdata = last status byte. No data access is made.
  - Otherwise: go to P_SETUP.
- RESP: rsp_valid = 1 for exactly one cycle.
  - Read: rsp_rdata = captured data.
  - Write: rsp_rdata = 0, rsp_timeout = 0.
  - Then go to IDLE.
- Latency with defaults and no polling: rsp_valid is high in cycle 5 after the accepting edge (1+1+2+1).
- Back-to-back requests: req_ready = 0 in RESP, so a request is taken at the earliest in the following IDLE cycle. p_cs_b is high for ≥ 2 cycles between accesses.
- Poll counter: cleared on acceptance; no wrap (saturates at POLL_LIMIT).
- Reset mid-transaction: at the next edge all strobes go high, p_data_oe = 0, state = IDLE. No rsp_valid is emitted for the aborted request.
- req_valid while busy is ignored (not queued).

Optional Feature:
- Macro: TUBE_PARASITE_MASTER_IRQ_SYNC_EN
- Enabled:
  - Adds inputs p_irq_b and p_nmi_b, each passed through a 2-flop synchroniser.
  - Adds outputs irq (= synchronised !p_irq_b) and nmi_pulse (one-cycle pulse on each synchronised falling edge of p_nmi_b).
  - Reset values: synchronisers reset to the inactive level (1), so irq = 0 and nmi_pulse = 0. No spurious pulse after reset.
- Disabled: these ports and their logic are absent.

Test Plan:
- Read, req_fifo = 0, req_wait = 0, p_data_in = 0xA5 → p_addr = 1, p_cs_b low 4 cycles, p_rd_b low 2 cycles, rsp_valid in cycle 5, rsp_rdata = 0xA5, rsp_timeout = 0.
- Write, req_fifo = 3, wdata = 0x3C → p_addr = 7, p_data_oe = 1 spanning p_wr_b low plus one hold cycle, p_data_out = 0x3C at p_wr_b rising, rsp_valid with rsp_rdata = 0.
- Read with req_wait = 1, status reads 0x7F twice then 0xFF, data 0x42 → three status reads at p_addr = 0 with p_cs_b high between, then one data read at p_addr = 1; rsp_rdata = 0x42.
- POLL_LIMIT = 4, write with req_wait = 1, status constantly 0xBF → 4 polls, no p_wr_b low ever, rsp_timeout = 1, rsp_rdata = 0xBF.
- p_rst asserted during STROBE of a write → next cycle p_cs_b = p_wr_b = 1, p_data_oe = 0, req_ready = 1, no rsp_valid.
- Two requests with req_valid held high → second accepted the cycle after RESP; p_cs_b high ≥ 2 cycles between accesses.
